// File: rtl/pmu_pkg.sv
// -----------------------------------------------------------------------------
// pmu_pkg
// Shared types and constants for the PMU counter-bank arbiter.
//   state_e       : arbiter FSM states
//   op_e          : latched operation of the granted requester
//   PMU_ADDR_W    : default counter address width
//   PMU_DATA_W    : default counter data width
//   PMU_ERR_RDATA : read data returned when a bank access times out
// -----------------------------------------------------------------------------
package pmu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    DRAIN
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  localparam int PMU_ADDR_W = 8;
  localparam int PMU_DATA_W = 64;

  localparam logic [PMU_DATA_W-1:0] PMU_ERR_RDATA = '0;

endpackage : pmu_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first set request at or after
// the pointer, wrapping around.
//   req_i   : request vector, one bit per requester
//   ptr_i   : index with highest priority this round
//   gnt_o   : one-hot grant (all zero when no request)
//   idx_o   : index of the granted requester
//   valid_o : at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  assign valid_o = |req_i;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    int  cand;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    cand  = 0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/pmu_bank_arbiter.sv
// -----------------------------------------------------------------------------
// pmu_bank_arbiter
// Shares the single PMU counter-bank port between N_REQ requesters, round
// robin, one transaction in flight. A watchdog completes stalled accesses
// with req_err so no requester hangs.
//   S_AXI_ACLK / S_AXI_ARESETN : clock, async active-low reset
//   req_rd_en / req_wr_en      : per-requester level requests
//   req_addr / req_wdata       : per-requester address / write data slices
//   req_rd_valid / req_wr_valid: one-hot, one-cycle completion pulses
//   req_rdata / req_err        : read data and timeout flag with the pulse
//   counter_*                  : bank read/write port (level enable/valid)
//   busy                       : FSM not in IDLE
// -----------------------------------------------------------------------------
module pmu_bank_arbiter
  import pmu_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = PMU_ADDR_W,
  parameter int DATA_W  = PMU_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [N_REQ-1:0]        req_rd_en,
  input  logic [N_REQ-1:0]        req_wr_en,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_rd_valid,
  output logic [N_REQ-1:0]        req_wr_valid,
  output logic [DATA_W-1:0]       req_rdata,
  output logic                    req_err,
  output logic                    counter_read_enable,
  input  logic                    counter_read_valid,
  output logic [ADDR_W-1:0]       counter_read_address,
  input  logic [DATA_W-1:0]       counter_read_data,
  output logic                    counter_write_enable,
  input  logic                    counter_write_valid,
  output logic [ADDR_W-1:0]       counter_write_address,
  output logic [DATA_W-1:0]       counter_write_data,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                en_q, en_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic [N_REQ-1:0]    req_vec;
  logic [N_REQ-1:0]    pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                bank_valid;
  logic                wd_hit;
  logic [WD_W-1:0]     wd_inc;

  assign req_vec = req_rd_en | req_wr_en;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (req_vec),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // The bank valid that belongs to the latched operation; the other one is
  // never looked at, even if the bank raises it.
  assign bank_valid = (op_q == OP_WR) ? counter_write_valid : counter_read_valid;
  assign wd_hit     = (wd_q >= WD_LAST);
  assign wd_inc     = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    en_d    = en_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gidx_d  = pick_idx;
          // Write wins when a requester asks for both.
          op_d    = (|(req_wr_en & pick_gnt)) ? OP_WR : OP_RD;
          addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          err_d   = 1'b0;
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Enable rises one cycle into ISSUE; the watchdog only runs while
        // the enable is visible to the bank.
        if (!en_q) begin
          en_d = 1'b1;
        end else if (bank_valid) begin
          en_d    = 1'b0;
          if (op_q == OP_RD) rdata_d = counter_read_data;
          state_d = RESP;
        end else if (wd_hit) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          rdata_d = DATA_W'(PMU_ERR_RDATA);
          state_d = RESP;
        end else begin
          wd_d = wd_inc;
        end
      end
      RESP: begin
        wd_d    = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        // The bank valid is level and may lag; a new grant before it drops
        // would let the stale valid complete the next access.
        if (!bank_valid || wd_hit) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      ptr_q   <= '0;
      gidx_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      en_q    <= en_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    req_rd_valid = '0;
    req_wr_valid = '0;
    if (state_q == RESP) begin
      if (op_q == OP_RD) req_rd_valid[gidx_q] = 1'b1;
      else               req_wr_valid[gidx_q] = 1'b1;
    end
  end

  assign req_rdata             = rdata_q;
  assign req_err               = (state_q == RESP) && err_q;
  assign counter_read_enable   = en_q && (op_q == OP_RD);
  assign counter_write_enable  = en_q && (op_q == OP_WR);
  assign counter_read_address  = addr_q;
  assign counter_write_address = addr_q;
  assign counter_write_data    = wdata_q;
  assign busy                  = (state_q != IDLE);

endmodule : pmu_bank_arbiter

// File: tb/tb_pmu_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmu_bank_arbiter
// Directed bench: 3 requesters, TIMEOUT=10, with a simple bank model whose
// response delay, valid hold time and silence are set per scenario.
// -----------------------------------------------------------------------------
module tb_pmu_bank_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_rd_en = '0;
  logic [N-1:0]    req_wr_en = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_rd_valid, req_wr_valid;
  logic [DW-1:0]   req_rdata;
  logic            req_err;
  logic            counter_read_enable, counter_write_enable;
  logic            counter_read_valid = 1'b0;
  logic            counter_write_valid = 1'b0;
  logic [AW-1:0]   counter_read_address, counter_write_address;
  logic [DW-1:0]   counter_read_data = '0;
  logic [DW-1:0]   counter_write_data;
  logic            busy;

  always #5 clk = ~clk;

  pmu_bank_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .S_AXI_ACLK            (clk),
    .S_AXI_ARESETN         (rst_n),
    .req_rd_en             (req_rd_en),
    .req_wr_en             (req_wr_en),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .req_rd_valid          (req_rd_valid),
    .req_wr_valid          (req_wr_valid),
    .req_rdata             (req_rdata),
    .req_err               (req_err),
    .counter_read_enable   (counter_read_enable),
    .counter_read_valid    (counter_read_valid),
    .counter_read_address  (counter_read_address),
    .counter_read_data     (counter_read_data),
    .counter_write_enable  (counter_write_enable),
    .counter_write_valid   (counter_write_valid),
    .counter_write_address (counter_write_address),
    .counter_write_data    (counter_write_data),
    .busy                  (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- bank model ----------------
  int            bank_delay = 1;
  int            bank_hold  = 0;
  bit            bank_mute  = 1'b0;
  logic [DW-1:0] bank_data  = '0;

  initial begin
    int rd_cnt, wr_cnt, rd_hold, wr_hold;
    rd_cnt = 0; wr_cnt = 0; rd_hold = 0; wr_hold = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        counter_read_valid  = 1'b0;
        counter_write_valid = 1'b0;
        rd_cnt = 0; wr_cnt = 0;
      end else begin
        if (counter_read_enable && !bank_mute) begin
          rd_cnt++;
          if (rd_cnt >= bank_delay) begin
            counter_read_valid = 1'b1;
            counter_read_data  = bank_data;
            rd_hold            = bank_hold;
          end
        end else begin
          rd_cnt = 0;
          if (counter_read_valid) begin
            if (rd_hold > 0) rd_hold--;
            else counter_read_valid = 1'b0;
          end
        end
        if (counter_write_enable && !bank_mute) begin
          wr_cnt++;
          if (wr_cnt >= bank_delay) begin
            counter_write_valid = 1'b1;
            wr_hold             = bank_hold;
          end
        end else begin
          wr_cnt = 0;
          if (counter_write_valid) begin
            if (wr_hold > 0) wr_hold--;
            else counter_write_valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int both_hi    = 0;
  int wr_pulses  = 0;
  int drain_viol = 0;

  always @(negedge clk) begin
    if (counter_read_enable && counter_write_enable) both_hi++;
    if (|req_wr_valid) wr_pulses++;
    if (counter_write_valid && counter_read_enable) drain_viol++;
  end

  // ---------------- helpers ----------------
  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wdata(input int i, input logic [DW-1:0] d);
    req_wdata[i*DW +: DW] = d;
  endtask

  // Wait for any completion pulse, sampled on negedges; a miss is a failure.
  task automatic wait_pulse(input string tag, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if ((|req_rd_valid) || (|req_wr_valid)) seen = 1'b1;
    end
    if (!seen) check({tag, "_no_pulse"}, 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, en_cyc, wr_base;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_enables", {counter_read_enable, counter_write_enable}, 0);
    check("rst_valids", {req_rd_valid, req_wr_valid}, 0);
    check("rst_rdata_err", {req_rdata, req_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read from requester 1, bank answers on the 3rd enable cycle.
    bank_delay = 3;
    bank_data  = 64'h1234_5678_9ABC_DEF0;
    set_addr(1, 8'h05);
    req_rd_en[1] = 1'b1;
    lat = 0;
    for (int i = 0; i < 20 && !counter_read_enable; i++) begin
      @(negedge clk);
      lat++;
    end
    check("t1_req_to_en", lat, 2);
    check("t1_addr", counter_read_address, 8'h05);
    wait_pulse("t1", 30);
    check("t1_rd_valid", req_rd_valid, 3'b010);
    check("t1_rdata", req_rdata, 64'h1234_5678_9ABC_DEF0);
    check("t1_err", req_err, 0);
    req_rd_en = '0;
    @(negedge clk);
    check("t1_pulse_width", req_rd_valid, 0);
    wait_idle();

    // Round robin from reset: all three read continuously.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    bank_delay = 1;
    req_rd_en  = 3'b111;
    for (int n = 0; n < 6; n++) begin
      wait_pulse($sformatf("rr%0d", n), 30);
      check($sformatf("rr_grant%0d", n), 64'(oh2idx(req_rd_valid)), 64'(n % 3));
    end
    req_rd_en = '0;
    wait_idle();

    // Read and write on requester 2: write goes first.
    bank_data = 64'h55;
    set_addr(2, 8'h22);
    set_wdata(2, 64'hAA);
    req_rd_en[2] = 1'b1;
    req_wr_en[2] = 1'b1;
    wait_pulse("t3_wr", 30);
    check("t3_wr_first", {req_wr_valid, req_rd_valid}, {3'b100, 3'b000});
    check("t3_wdata", counter_write_data, 64'hAA);
    check("t3_waddr", counter_write_address, 8'h22);
    req_wr_en = '0;
    wait_pulse("t3_rd", 30);
    check("t3_rd_second", req_rd_valid, 3'b100);
    check("t3_rdata", req_rdata, 64'h55);
    req_rd_en = '0;
    wait_idle();

    // Watchdog: bank stays silent.
    bank_mute = 1'b1;
    set_addr(0, 8'h10);
    req_rd_en[0] = 1'b1;
    en_cyc = 0;
    seen   = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (counter_read_enable) en_cyc++;
      if (|req_rd_valid) seen = 1'b1;
    end
    check("t4_pulse_seen", seen, 1);
    check("t4_en_cycles", en_cyc, TO);
    check("t4_rd_valid", req_rd_valid, 3'b001);
    check("t4_err", req_err, 1);
    check("t4_rdata_zero", req_rdata, 0);
    req_rd_en = '0;
    bank_mute = 1'b0;
    bank_data = 64'hBEEF;
    req_rd_en[1] = 1'b1;
    wait_pulse("t4_next", 30);
    check("t4_next_valid", req_rd_valid, 3'b010);
    check("t4_next_err", req_err, 0);
    req_rd_en = '0;
    wait_idle();

    // Slow drain: write valid lingers 4 cycles, requester 1 read waits.
    bank_hold  = 4;
    drain_viol = 0;
    wr_base    = wr_pulses;
    set_wdata(0, 64'h77);
    set_addr(1, 8'h31);
    req_wr_en[0] = 1'b1;
    req_rd_en[1] = 1'b1;
    wait_pulse("t5_wr", 30);
    check("t5_wr_valid", req_wr_valid, 3'b001);
    req_wr_en = '0;
    wait_pulse("t5_rd", 40);
    check("t5_rd_valid", req_rd_valid, 3'b010);
    req_rd_en = '0;
    check("t5_wr_pulses", wr_pulses - wr_base, 1);
    check("t5_no_early_grant", drain_viol, 0);
    wait_idle();
    bank_hold = 0;
    repeat (8) @(negedge clk);

    // Async reset while a read is in ISSUE.
    bank_mute = 1'b1;
    req_rd_en[0] = 1'b1;
    for (int i = 0; i < 20 && !counter_read_enable; i++) @(negedge clk);
    check("t6_en_before", counter_read_enable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_en_cleared", counter_read_enable, 0);
    check("t6_busy_cleared", busy, 0);
    check("t6_valids_cleared", {req_rd_valid, req_wr_valid}, 0);
    req_rd_en = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    bank_mute = 1'b0;
    req_rd_en = 3'b011;
    wait_pulse("t6_after", 30);
    check("t6_ptr_reset", req_rd_valid, 3'b001);
    req_rd_en = '0;
    wait_idle();

    check("enables_exclusive", both_hi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

endmodule : tb_pmu_bank_arbiter
